// File: rtl/mipi_csi_packet_encoder_if.sv
// mipi_csi_packet_encoder_if: payload/request inputs and lane-aligned output of the CSI-2 packet encoder
interface mipi_csi_packet_encoder_if;
    logic        start_i;
    logic [7:0]  packet_type_i;
    logic [15:0] word_count_i;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] data_o;
    logic        output_valid_o;
    logic        busy_o;
    logic        underrun_o;
    modport master (
        output start_i, packet_type_i, word_count_i, data_i, data_valid_i,
        input  data_ready_o, data_o, output_valid_o, busy_o, underrun_o
    );
    modport slave (
        input  start_i, packet_type_i, word_count_i, data_i, data_valid_i,
        output data_ready_o, data_o, output_valid_o, busy_o, underrun_o
    );
endinterface

// File: rtl/mipi_csi_packet_encoder.sv
// mipi_csi_packet_encoder: CSI-2 4-lane packet builder (sync, header+ECC, payload, CRC-16 footer, idle gap)
module mipi_csi_packet_encoder #(
    parameter logic [7:0] SYNC_BYTE  = 8'hB8,
    parameter int         GAP_CYCLES = 4
) (
    input logic clk_i,
    input logic reset_i,
    mipi_csi_packet_encoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SYNC, HEADER, PAYLOAD, FOOTER, GAP} state_t;
    state_t      state, state_n;
    logic [7:0]  di, di_n, gap, gap_n;
    logic [15:0] wc, wc_n, crc, crc_n;
    logic [14:0] cnt, cnt_n, n_words;
    logic [31:0] dout, dout_n, w, w_last;
    logic        vout, vout_n, unr, unr_n;
    logic [16:0] wc_p3;
    logic [1:0]  r;
    logic        is_long, ready, last;
    logic [15:0] c1, c2, c3, c4, crc_w;
    logic [23:0] d;
    logic [5:0]  ecc;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c;
        for (int i = 0; i < 8; i++) x = (x[0] ^ b[i]) ? (x >> 1) ^ 16'h8408 : x >> 1;
        return x;
    endfunction

    assign wc_p3   = {1'b0, wc} + 17'd3;
    assign n_words = wc_p3[16:2];
    assign r       = wc[1:0];
    assign is_long = di[5:0] >= 6'h10;
    assign last    = cnt == n_words - 15'd1;
    assign ready   = (state == HEADER && is_long && wc != 16'd0) || (state == PAYLOAD && cnt != n_words);
    assign w       = bus.data_valid_i ? bus.data_i : 32'h0;
    assign c1      = crc_byte(crc, w[7:0]);
    assign c2      = crc_byte(c1, w[15:8]);
    assign c3      = crc_byte(c2, w[23:16]);
    assign c4      = crc_byte(c3, w[31:24]);
    // The final word carries only the valid bytes; for r=1..3 the CRC is folded into its spare lanes
    assign crc_w   = !last ? c4 : r == 2'd1 ? c1 : r == 2'd2 ? c2 : r == 2'd3 ? c3 : c4;
    assign w_last  = r == 2'd1 ? {8'h00, c1, w[7:0]} : r == 2'd2 ? {c2, w[15:0]} :
                     r == 2'd3 ? {c3[7:0], w[23:0]} : w;
    assign d       = {wc, di};
    assign ecc[0]  = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10], d[11], d[13], d[16], d[20], d[21], d[22], d[23]};
    assign ecc[1]  = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10], d[12], d[14], d[17], d[20], d[21], d[22], d[23]};
    assign ecc[2]  = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11], d[12], d[15], d[18], d[20], d[21], d[22]};
    assign ecc[3]  = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13], d[14], d[15], d[19], d[20], d[21], d[23]};
    assign ecc[4]  = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16], d[17], d[18], d[19], d[20], d[22], d[23]};
    assign ecc[5]  = ^{d[10], d[11], d[12], d[13], d[14], d[15], d[16], d[17], d[18], d[19], d[21], d[22], d[23]};

    always_comb begin
        state_n = state;
        di_n    = di;
        wc_n    = wc;
        cnt_n   = cnt;
        crc_n   = crc;
        gap_n   = state != GAP ? 8'(GAP_CYCLES - 1) : gap - 8'd1;
        dout_n  = 32'h0;
        vout_n  = 1'b0;
        unr_n   = unr | (ready & ~bus.data_valid_i);
        if (ready) begin
            dout_n = last ? w_last : w;
            vout_n = 1'b1;
            crc_n  = crc_w;
            cnt_n  = cnt + 15'd1;
        end
        case (state)
            IDLE: if (bus.start_i) begin
                state_n = SYNC;
                di_n    = bus.packet_type_i;
                wc_n    = bus.word_count_i;
                cnt_n   = 15'd0;
                crc_n   = 16'hFFFF;
                dout_n  = {4{SYNC_BYTE}};
                vout_n  = 1'b1;
            end
            SYNC: begin
                state_n = HEADER;
                dout_n  = {2'b00, ecc, wc, di};
                vout_n  = 1'b1;
            end
            HEADER:  if (!is_long) state_n = GAP; else if (wc == 16'd0) state_n = FOOTER; else state_n = PAYLOAD;
            PAYLOAD: if (cnt == n_words) state_n = (r == 2'd1 || r == 2'd2) ? GAP : FOOTER;
            FOOTER:  state_n = GAP;
            GAP:     if (gap == 8'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n == FOOTER) begin
            dout_n = r == 2'd3 ? {24'h0, crc[15:8]} : {16'h0, crc};
            vout_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            di    <= 8'h0;
            wc    <= 16'h0;
            cnt   <= 15'd0;
            crc   <= 16'hFFFF;
            gap   <= 8'h0;
            dout  <= 32'h0;
            vout  <= 1'b0;
            unr   <= 1'b0;
        end else begin
            state <= state_n;
            di    <= di_n;
            wc    <= wc_n;
            cnt   <= cnt_n;
            crc   <= crc_n;
            gap   <= gap_n;
            dout  <= dout_n;
            vout  <= vout_n;
            unr   <= unr_n;
        end
    end

    assign bus.data_o         = dout;
    assign bus.output_valid_o = vout;
    assign bus.data_ready_o   = ready;
    assign bus.busy_o         = state != IDLE;
    assign bus.underrun_o     = unr;
endmodule

// File: tb/tb_mipi_csi_packet_encoder.sv
// tb_mipi_csi_packet_encoder: scoreboard bench for the CSI-2 packet encoder
module tb_mipi_csi_packet_encoder;
    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    mipi_csi_packet_encoder_if bus();
    mipi_csi_packet_encoder #(.SYNC_BYTE(8'hB8), .GAP_CYCLES(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus)
    );

    localparam logic [23:0] ECC_M [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_unr = 1'b0;
    logic [31:0] exp_q[$];
    logic [7:0]  pay[];
    logic [31:0] hdr, last_w;

    function automatic logic [5:0] ecc_model(input logic [23:0] dd);
        logic [5:0] e;
        for (int k = 0; k < 6; k++) e[k] = ^(dd & ECC_M[k]);
        return e;
    endfunction

    function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) begin
            c ^= {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
        end
        return c;
    endfunction

    task automatic fill_rand(input int wc);
        pay = new[((wc + 3) / 4) * 4];
        foreach (pay[i]) pay[i] = 8'($urandom);
    endtask

    // Expected stream: sync, header, then WC bytes + CRC lo/hi padded with zeros to whole words
    task automatic build_expected(input logic [7:0] di, input logic [15:0] wc, input int df, input int dl);
        logic [7:0]  s[$];
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(32'hB8B8B8B8);
        exp_q.push_back({2'b00, ecc_model({wc, di}), wc, di});
        if (di[5:0] >= 6'h10) begin
            for (int i = 0; i < int'(wc); i++) s.push_back((i / 4 >= df && i / 4 < df + dl) ? 8'h00 : pay[i]);
            c = crc_model(s);
            s.push_back(c[7:0]);
            s.push_back(c[15:8]);
            while (s.size() % 4 != 0) s.push_back(8'h00);
            for (int i = 0; i < s.size(); i += 4) exp_q.push_back({s[i+3], s[i+2], s[i+1], s[i]});
        end
    endtask

    task automatic drive_word(input int idx, input int nw, input int df, input int dl);
        bus.data_valid_i = !(idx >= df && idx < df + dl);
        bus.data_i = (idx < nw && 4 * idx + 3 < pay.size()) ?
                     {pay[4*idx+3], pay[4*idx+2], pay[4*idx+1], pay[4*idx]} : $urandom;
    endtask

    task automatic run_pkt(input string name, input logic [7:0] di, input logic [15:0] wc,
                           input int df, input int dl, output logic [31:0] hdr_o, output logic [31:0] last_o);
        int          n_words = (int'(wc) + 3) / 4;
        int          n_exp, n_seen = 0, taken = 0, gap = 0, first = -1, idx = 0;
        bit          done = 0;
        bit          is_long = di[5:0] >= 6'h10;
        logic [31:0] exp;
        hdr_o = 32'h0;
        last_o = 32'h0;
        build_expected(di, wc, df, dl);
        n_exp = exp_q.size();
        if (is_long && dl > 0 && n_words > df) exp_unr = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i = 1'b1;
        bus.packet_type_i = di;
        bus.word_count_i = wc;
        drive_word(idx, n_words, df, dl);
        for (int cyc = 0; cyc < n_words + 32 && !done; cyc++) begin
            @(negedge clk_i);
            if (bus.output_valid_o) begin
                if (first < 0) first = cyc;
                n_seen++;
                if (n_seen == 2) hdr_o = bus.data_o;
                last_o = bus.data_o;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s extra_word: got %h, required none", name, bus.data_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.data_o !== exp) begin
                        n_bad++;
                        $display("FAIL %s word%0d: got %h, required %h", name, n_seen - 1, bus.data_o, exp);
                    end
                end
            end else if (n_seen > 0) begin
                if (bus.busy_o) begin
                    gap++;
                    n_cmp++;
                    if (bus.data_o !== 32'h0) begin
                        n_bad++;
                        $display("FAIL %s gap_data: got %h, required 0", name, bus.data_o);
                    end
                end else done = 1;
            end
            if (bus.data_ready_o) begin
                taken++;
                idx++;
            end
            @(posedge clk_i); #1;
            bus.start_i = 1'b0;
            drive_word(idx, n_words, df, dl);
        end
        n_cmp += 6;
        if (!done) begin n_bad++; $display("FAIL %s timeout: packet did not return to idle", name); end
        if (first !== 1) begin n_bad++; $display("FAIL %s latency: first valid at %0d, required 1", name, first); end
        if (n_seen !== n_exp) begin n_bad++; $display("FAIL %s length: got %0d words, required %0d", name, n_seen, n_exp); end
        if (taken !== (is_long ? n_words : 0)) begin
            n_bad++; $display("FAIL %s ready_count: got %0d, required %0d", name, taken, is_long ? n_words : 0);
        end
        if (gap !== 4) begin n_bad++; $display("FAIL %s gap_len: got %0d, required 4", name, gap); end
        if (bus.underrun_o !== exp_unr) begin
            n_bad++; $display("FAIL %s underrun: got %b, required %b", name, bus.underrun_o, exp_unr);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp += 5;
        if (bus.data_o !== 32'h0) begin n_bad++; $display("FAIL %s data_o: got %h, required 0", name, bus.data_o); end
        if (bus.output_valid_o !== 1'b0) begin n_bad++; $display("FAIL %s valid: got %b, required 0", name, bus.output_valid_o); end
        if (bus.data_ready_o !== 1'b0) begin n_bad++; $display("FAIL %s ready: got %b, required 0", name, bus.data_ready_o); end
        if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b, required 0", name, bus.busy_o); end
        if (bus.underrun_o !== 1'b0) begin n_bad++; $display("FAIL %s underrun: got %b, required 0", name, bus.underrun_o); end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        exp_unr = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("reset");
    endtask

    task automatic test_short();
        run_pkt("short_d8", 8'h00, 16'h0001, 0, 0, hdr, last_w);
        run_pkt("short_d23", 8'h00, 16'h8000, 0, 0, hdr, last_w);
        n_cmp++;
        if (hdr !== 32'h3B800000) begin n_bad++; $display("FAIL short_d23 header: got %h, required 3b800000", hdr); end
        run_pkt("short_d0", 8'h01, 16'h0000, 0, 0, hdr, last_w);
        n_cmp++;
        if (hdr !== 32'h07000001) begin n_bad++; $display("FAIL short_d0 header: got %h, required 07000001", hdr); end
    endtask

    task automatic test_long_known();
        logic [7:0] kv [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
                               8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        pay = new[24];
        foreach (kv[i]) pay[i] = kv[i];
        run_pkt("long_known", 8'h2B, 16'd24, 0, 0, hdr, last_w);
        n_cmp++;
        if (last_w !== 32'h000000F0) begin n_bad++; $display("FAIL long_known footer: got %h, required 000000f0", last_w); end
    endtask

    task automatic test_wc_zero();
        fill_rand(0);
        run_pkt("long_wc0", 8'h2B, 16'd0, 0, 0, hdr, last_w);
        n_cmp++;
        if (last_w !== 32'h0000FFFF) begin n_bad++; $display("FAIL long_wc0 footer: got %h, required 0000ffff", last_w); end
    endtask

    task automatic test_remainders();
        for (int wc = 5; wc <= 8; wc++) begin
            fill_rand(wc);
            run_pkt($sformatf("rem_wc%0d", wc), 8'h2A, 16'(wc), 0, 0, hdr, last_w);
        end
    endtask

    task automatic test_max_wc();
        fill_rand(65535);
        run_pkt("wc_ffff", 8'h6C, 16'hFFFF, 0, 0, hdr, last_w);
    endtask

    task automatic test_underrun();
        fill_rand(32);
        run_pkt("underrun", 8'h2B, 16'd32, 3, 2, hdr, last_w);
    endtask

    task automatic test_reset_mid();
        fill_rand(64);
        @(posedge clk_i); #1;
        bus.start_i = 1'b1;
        bus.packet_type_i = 8'h2B;
        bus.word_count_i = 16'd64;
        for (int i = 0; i < 6; i++) begin
            drive_word(i, 16, 0, 0);
            @(posedge clk_i); #1;
            bus.start_i = 1'b0;
        end
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        exp_unr = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("reset_mid");
    endtask

    task automatic test_back_to_back();
        fill_rand(6);
        run_pkt("after_reset", 8'h2B, 16'd6, 0, 0, hdr, last_w);
        fill_rand(11);
        run_pkt("b2b_wc11", 8'h24, 16'd11, 0, 0, hdr, last_w);
    endtask

    initial begin
        reset_i = 1'b1;
        bus.start_i = 1'b0;
        bus.packet_type_i = 8'h0;
        bus.word_count_i = 16'h0;
        bus.data_i = 32'h0;
        bus.data_valid_i = 1'b0;
        test_reset();
        test_short();
        test_long_known();
        test_wc_zero();
        test_remainders();
        test_max_wc();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
